// File: rtl/red_light_monitor.sv
// Red-light monitor: tracks the lamp sequence from the traffic controller,
// flags illegal sequences and triggers a camera on red-light violations.
module red_light_monitor #(
  parameter int YEL_MIN   = 2,
  parameter int GRACE     = 1,
  parameter int CAM_PULSE = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             green,
  input  logic             yellow,
  input  logic             red,
  input  logic             s,
  output logic             camera_trig,
  output logic [CNT_W-1:0] violation_cnt,
  output logic             fault,
  output logic [1:0]       phase
);

  localparam int CAM_W = $clog2(CAM_PULSE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_RED    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             state_r, state_nxt_s;
  logic               glitch_r, glitch_nxt_s;
  logic [1:0]         phase_r, phase_nxt_s;
  logic [CNT_W-1:0]   yel_cnt_r, yel_nxt_s;
  logic [CNT_W-1:0]   red_cnt_r, red_nxt_s;
  logic [CNT_W-1:0]   vcnt_r, vcnt_nxt_s;
  logic [CAM_W-1:0]   cam_cnt_r, cam_nxt_s;
  logic               cam_trig_r;
  logic               s_q_r;

  logic [2:0] lamps_s;
  logic       one_hot_s;
  logic       any_s;
  logic       rise_s;
  logic       viol_s;

  assign lamps_s   = {green, yellow, red};
  assign one_hot_s = (lamps_s == 3'b100) || (lamps_s == 3'b010) || (lamps_s == 3'b001);
  assign any_s     = |lamps_s;
  assign rise_s    = s & ~s_q_r;
  assign viol_s    = (state_r == S_RED) && red && rise_s && (red_cnt_r >= CNT_W'(GRACE));

  // Sequence checker: phase tracking, glitch filtering and phase counters
  always_comb begin
    state_nxt_s  = state_r;
    glitch_nxt_s = 1'b0;
    phase_nxt_s  = phase_r;
    yel_nxt_s    = yel_cnt_r;
    red_nxt_s    = red_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (!any_s) begin
          state_nxt_s = S_IDLE;
        end else if (one_hot_s) begin
          if (green) begin
            state_nxt_s = S_GREEN;
            phase_nxt_s = 2'd1;
          end else if (yellow) begin
            state_nxt_s = S_YELLOW;
            phase_nxt_s = 2'd2;
            yel_nxt_s   = CNT_W'(1);
          end else begin
            state_nxt_s = S_RED;
            phase_nxt_s = 2'd3;
            red_nxt_s   = '0;
          end
        end else if (glitch_r) begin
          state_nxt_s = S_FAULT;
        end else begin
          glitch_nxt_s = 1'b1;
        end
      end
      S_GREEN: begin
        if (!one_hot_s) begin
          if (glitch_r) state_nxt_s = S_FAULT;
          else          glitch_nxt_s = 1'b1;
        end else if (green) begin
          state_nxt_s = S_GREEN;
        end else if (yellow) begin
          state_nxt_s = S_YELLOW;
          phase_nxt_s = 2'd2;
          yel_nxt_s   = CNT_W'(1);
        end else begin
          state_nxt_s = S_FAULT;
        end
      end
      S_YELLOW: begin
        if (!one_hot_s) begin
          if (glitch_r) state_nxt_s = S_FAULT;
          else          glitch_nxt_s = 1'b1;
        end else if (yellow) begin
          if (yel_cnt_r != CNT_MAX) yel_nxt_s = yel_cnt_r + CNT_W'(1);
          else                      yel_nxt_s = yel_cnt_r;
        end else if (red) begin
          // A yellow phase shorter than YEL_MIN is a controller fault
          if (yel_cnt_r < CNT_W'(YEL_MIN)) begin
            state_nxt_s = S_FAULT;
          end else begin
            state_nxt_s = S_RED;
            phase_nxt_s = 2'd3;
            red_nxt_s   = '0;
          end
        end else begin
          state_nxt_s = S_FAULT;
        end
      end
      S_RED: begin
        if (!one_hot_s) begin
          if (glitch_r) state_nxt_s = S_FAULT;
          else          glitch_nxt_s = 1'b1;
        end else if (red) begin
          if (red_cnt_r != CNT_MAX) red_nxt_s = red_cnt_r + CNT_W'(1);
          else                      red_nxt_s = red_cnt_r;
        end else if (green) begin
          state_nxt_s = S_GREEN;
          phase_nxt_s = 2'd1;
        end else begin
          state_nxt_s = S_FAULT;
        end
      end
      S_FAULT: begin
        state_nxt_s = S_FAULT;
      end
      default: begin
        state_nxt_s = S_FAULT;
      end
    endcase
  end

  // Violation counter and camera pulse down-counter
  always_comb begin
    vcnt_nxt_s = vcnt_r;
    cam_nxt_s  = cam_cnt_r;
    if (viol_s && (vcnt_r != CNT_MAX)) vcnt_nxt_s = vcnt_r + CNT_W'(1);
    else                               vcnt_nxt_s = vcnt_r;
    if (state_r == S_FAULT) begin
      cam_nxt_s = '0;
    end else if (viol_s && (cam_cnt_r == '0)) begin
      cam_nxt_s = CAM_W'(CAM_PULSE);
    end else if (cam_cnt_r != '0) begin
      cam_nxt_s = cam_cnt_r - CAM_W'(1);
    end else begin
      cam_nxt_s = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      glitch_r   <= 1'b0;
      phase_r    <= 2'd0;
      yel_cnt_r  <= '0;
      red_cnt_r  <= '0;
      vcnt_r     <= '0;
      cam_cnt_r  <= '0;
      cam_trig_r <= 1'b0;
      s_q_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      glitch_r   <= glitch_nxt_s;
      phase_r    <= phase_nxt_s;
      yel_cnt_r  <= yel_nxt_s;
      red_cnt_r  <= red_nxt_s;
      vcnt_r     <= vcnt_nxt_s;
      cam_cnt_r  <= cam_nxt_s;
      cam_trig_r <= (cam_nxt_s != '0);
      s_q_r      <= s;
    end
  end

  assign camera_trig   = cam_trig_r;
  assign violation_cnt = vcnt_r;
  assign fault         = (state_r == S_FAULT);
  assign phase         = phase_r;

endmodule

// File: doc/red_light_monitor.md
Name: red_light_monitor

Overview:
- Consumer end of the traffic-light output interface: samples the green/yellow/red lamp lines from the traffic controller, plus the stop-line vehicle sensor s.
- Checks that the lamp sequence is legal (G->Y->R->G, minimum yellow length, one-hot lamps).
- Detects red-light runners, fires a fixed-length camera trigger pulse and keeps a saturating violation count.
- Sits beside the traffic controller at top level. Same clk (1 s period in system benches).

Parameters:
YEL_MIN, 2, minimum number of cycles yellow must be sampled before red, else fault
GRACE, 1, red cycles (red_cnt value) required before a sensor edge counts as a violation
CAM_PULSE, 3, camera_trig high time in cycles
CNT_W, 8, width of violation_cnt and internal phase counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
green  input  1  green lamp from traffic controller
yellow  input  1  yellow lamp from traffic controller
red  input  1  red lamp from traffic controller
s  input  1  vehicle sensor, high while a vehicle crosses the stop line
camera_trig  output  1  registered camera pulse, CAM_PULSE cycles per violation
violation_cnt  output  CNT_W  saturating count of violations
fault  output  1  sticky sequence/encoding fault flag
phase  output  2  current tracked phase: 0 IDLE, 1 GREEN, 2 YELLOW, 3 RED

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, phase=0, camera_trig=0, violation_cnt=0, fault=0, s_q=0, all counters 0. Reset mid-pulse or in FAULT clears everything on that edge.
- All decisions at an edge use the current registered state and the current input values. s_q is s delayed one edge. rise = s & ~s_q.
- States: IDLE, GREEN, YELLOW, RED, FAULT.
- IDLE:
  - All lamps off: stay, no fault.
  - Exactly one lamp on: go to that lamp's state.
  - Multi-hot for 2 consecutive edges: go to FAULT.
- GREEN / YELLOW / RED:
  - Same lamp still on: stay.
  - Legal next lamp (G->Y, Y->R, R->G) one-hot: transition.
  - Illegal one-hot jump (G->R, Y->G, R->Y): FAULT on that edge.
  - Non-one-hot (off or multi-hot) on a single edge: glitch. Hold state and counters.
  - Non-one-hot on 2 consecutive edges: FAULT.
- yel_cnt:
  - Set to 1 on YELLOW entry; increments each edge yellow stays sampled; saturates at 2^CNT_W-1.
  - Y->R with yel_cnt < YEL_MIN: FAULT instead of RED.
- red_cnt:
  - Set to 0 on RED entry; increments each edge in RED with red=1; saturates.
- Violation: state==RED && red==1 && rise && red_cnt >= GRACE.
  - A sensor edge on the same edge as R->G (red=0) is not a violation.
  - A sensor edge in GREEN or YELLOW is never a violation.
- On a violation:
  - violation_cnt increments, saturating at 2^CNT_W-1 (holds there, no wrap).
  - If the camera is idle, camera_trig goes high from this edge for exactly CAM_PULSE cycles, via a down-counter.
  - If a pulse is already active, the count still increments; the pulse is not restarted or extended.
- FAULT:
  - fault=1, phase reports the last legal phase.
  - camera_trig forced 0 from the next edge; an in-flight pulse is truncated.
  - No further counting.
  - Exit only by reset.
- s held high continuously produces one rise only.
- Latency: camera_trig and violation_cnt update on the same edge that samples the qualifying rise (registered outputs, visible after that edge).

Test Plan:
- Reset, then G 5 cycles, Y 2, R 6, G -> phase follows 1,2,3,1. fault=0, violation_cnt=0, camera_trig never high.
- In RED with red_cnt=3, s 0->1 held 4 cycles -> violation_cnt=1. camera_trig high exactly 3 cycles starting that edge. No second count.
- Two sensor rises 2 cycles apart in RED -> violation_cnt=2. Single 3-cycle camera pulse (no retrigger).
- s rise on the RED entry edge (red_cnt=0 < GRACE=1) -> no violation. Same with s rising while green -> violation_cnt unchanged.
- Yellow only 1 cycle before red -> fault=1 on the red edge. Later red + s rise -> no count, no trigger. rst_n=0 for one edge -> fault=0, phase=0.
- Lamp lines all 0 for 1 cycle in GREEN -> no fault, phase stays 1. All 0 for 2 cycles -> fault=1. Separately, force 255 violations -> violation_cnt stays 255 on the 256th.
